// File: rtl/maxnet_input_loader_if.sv
// Handshake bundle between the candidate stream, the MaxNet input loader and the
// MaxNet controller: word stream in, packed 4-entry vector out, finish back.
interface maxnet_input_loader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] x_0;
    logic [DATA_W-1:0] x_1;
    logic [DATA_W-1:0] x_2;
    logic [DATA_W-1:0] x_3;
    logic [2:0]        vec_count;
    logic              vec_valid;
    logic              vec_ready;
    logic              mn_finish;
    logic              busy;

    modport master (
        output in_data, in_valid, in_last, vec_ready, mn_finish,
        input  in_ready, x_0, x_1, x_2, x_3, vec_count, vec_valid, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, vec_ready, mn_finish,
        output in_ready, x_0, x_1, x_2, x_3, vec_count, vec_valid, busy
    );
endinterface

// File: rtl/maxnet_input_loader.sv
// Packs a word stream into one 4-entry MaxNet vector, offers it, then blocks until finish rises.
// Optional MAXNET_LOADER_CLAMP_NEG_EN: words with the top bit set are stored as zero.
module maxnet_input_loader #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 4
) (
    input logic                   clk,
    input logic                   rst,
    maxnet_input_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        S_FILL      = 2'd0,
        S_PRESENT   = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_x [NUM_IN];
    logic [2:0]        r_cnt;
    logic              r_fin_prev;

    logic              w_in_ready;
    logic              w_vec_valid;
    logic              w_busy;
    logic              w_accept;
    logic              w_fill_done;
    logic              w_vec_xfer;
    logic              w_finish_rise;
    logic              w_done;
    logic [DATA_W-1:0] w_word;

    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_fill_done   = w_accept & (bus.in_last | (r_idx == 2'(NUM_IN - 1)));
    assign w_vec_xfer    = w_vec_valid & bus.vec_ready;
    assign w_finish_rise = bus.mn_finish & ~r_fin_prev;
    assign w_done        = (r_state == S_WAIT_DONE) & w_finish_rise;

`ifdef MAXNET_LOADER_CLAMP_NEG_EN
    assign w_word = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
    assign w_word = bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL:      if (w_fill_done)   w_next = S_PRESENT;
            S_PRESENT:   if (w_vec_xfer)    w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (w_finish_rise) w_next = S_FILL;
            default:                        w_next = S_FILL;
        endcase
    end

    // in_ready is gated by rst so nothing is accepted while reset is asserted.
    always_comb begin
        w_in_ready  = 1'b0;
        w_vec_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_FILL:      w_in_ready  = rst;
            S_PRESENT: begin
                w_vec_valid = 1'b1;
                w_busy      = 1'b1;
            end
            S_WAIT_DONE: w_busy      = 1'b1;
            default: ;
        endcase
    end

    // Slots are cleared when returning to FILL so a short vector carries zero padding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx      <= 2'd0;
            r_cnt      <= 3'd0;
            r_fin_prev <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            r_fin_prev <= bus.mn_finish;
            if (w_accept) begin
                r_x[r_idx] <= w_word;
                r_cnt      <= {1'b0, r_idx} + 3'd1;
                r_idx      <= w_fill_done ? 2'd0 : r_idx + 2'd1;
            end else if (w_done) begin
                r_idx <= 2'd0;
                r_cnt <= 3'd0;
                for (int i = 0; i < NUM_IN; i++) begin
                    r_x[i] <= '0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.vec_valid = w_vec_valid;
    assign bus.busy      = w_busy;
    assign bus.x_0       = r_x[0];
    assign bus.x_1       = r_x[1];
    assign bus.x_2       = r_x[2];
    assign bus.x_3       = r_x[3];
    assign bus.vec_count = r_cnt;
endmodule

// File: tb/tb_maxnet_input_loader.sv
// Scoreboard bench for maxnet_input_loader: vectors queued as driven, compared at the vec handshake.
module tb_maxnet_input_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;

    maxnet_input_loader_if #(.DATA_W(32)) bus_if ();

    maxnet_input_loader #(.DATA_W(32), .NUM_IN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] x0;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] x3;
        logic [2:0]  cnt;
    } vec_t;

    vec_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_hs  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl(input logic [31:0] d);
`ifdef MAXNET_LOADER_CLAMP_NEG_EN
        return d[31] ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    always @(negedge clk) begin
        vec_t e;
        if (rst && bus_if.vec_valid && bus_if.vec_ready) begin
            n_hs++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("hs_x0",  bus_if.x_0, e.x0);
                check("hs_x1",  bus_if.x_1, e.x1);
                check("hs_x2",  bus_if.x_2, e.x2);
                check("hs_x3",  bus_if.x_3, e.x3);
                check("hs_cnt", 32'(bus_if.vec_count), 32'(e.cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input bit last);
        bus_if.in_data  = d;
        bus_if.in_valid = 1'b1;
        bus_if.in_last  = last;
        @(negedge clk);
        check("in_ready_fill", 32'(bus_if.in_ready), 32'd1);
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input int n, input bit last_final);
        vec_t        e;
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        e.x0  = (n > 0) ? mdl(w0) : 32'h0;
        e.x1  = (n > 1) ? mdl(w1) : 32'h0;
        e.x2  = (n > 2) ? mdl(w2) : 32'h0;
        e.x3  = (n > 3) ? mdl(w3) : 32'h0;
        e.cnt = 3'(n);
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            send_word(w[i], last_final && (i == n - 1));
        end
    endtask

    task automatic handshake();
        int start;
        int k;
        start = n_hs;
        k = 0;
        bus_if.vec_ready = 1'b1;
        while (n_hs == start && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_hs == start) check("hs_timeout", 32'd0, 32'd1);
        tick();
        bus_if.vec_ready = 1'b0;
        @(negedge clk);
        check("wait_vec_valid", 32'(bus_if.vec_valid), 32'd0);
        check("wait_busy", 32'(bus_if.busy), 32'd1);
        tick();
    endtask

    task automatic finish_pulse();
        bus_if.mn_finish = 1'b1;
        tick();
        bus_if.mn_finish = 1'b0;
        @(negedge clk);
        check("fill_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("fill_busy", 32'(bus_if.busy), 32'd0);
        check("fill_cleared", bus_if.x_0, 32'h0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_data   = '0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.vec_ready = 1'b0;
        bus_if.mn_finish = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready",  32'(bus_if.in_ready), 32'd0);
        check("rst_vec_valid", 32'(bus_if.vec_valid), 32'd0);
        check("rst_busy",      32'(bus_if.busy), 32'd0);
        check("rst_x0",        bus_if.x_0, 32'h0);
        check("rst_cnt",       32'(bus_if.vec_count), 32'd0);
        rst = 1'b1;
        tick();

        // Full vector, no gaps.
        send_vec(32'd5, 32'd9, 32'd3, 32'd7, 4, 1'b0);
        @(negedge clk);
        check("p1_vec_valid", 32'(bus_if.vec_valid), 32'd1);
        check("p1_busy",      32'(bus_if.busy), 32'd1);
        check("p1_in_ready",  32'(bus_if.in_ready), 32'd0);
        check("p1_cnt",       32'(bus_if.vec_count), 32'd4);
        check("p1_x2",        bus_if.x_2, 32'd3);
        tick();
        handshake();
        finish_pulse();

        // Unqualified in_last is ignored, then a short vector.
        bus_if.in_last = 1'b1;
        tick();
        bus_if.in_last = 1'b0;
        @(negedge clk);
        check("lastnv_in_ready",  32'(bus_if.in_ready), 32'd1);
        check("lastnv_vec_valid", 32'(bus_if.vec_valid), 32'd0);
        tick();
        send_vec(32'd12, 32'd4, 32'd0, 32'd0, 2, 1'b1);
        @(negedge clk);
        check("p2_vec_valid", 32'(bus_if.vec_valid), 32'd1);
        check("p2_cnt",       32'(bus_if.vec_count), 32'd2);
        check("p2_x2",        bus_if.x_2, 32'h0);
        check("p2_x3",        bus_if.x_3, 32'h0);
        tick();
        handshake();
        finish_pulse();

        // Stall in PRESENT with traffic on the input side.
        send_vec(32'h11, 32'h22, 32'h33, 32'h44, 4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = $urandom;
            @(negedge clk);
            check("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
            check("stall_vec_valid", 32'(bus_if.vec_valid), 32'd1);
            check("stall_x0", bus_if.x_0, 32'h11);
            check("stall_x3", bus_if.x_3, 32'h44);
            tick();
        end
        bus_if.in_valid = 1'b0;

        // Finish high from the handshake onward must not count as completion.
        bus_if.mn_finish = 1'b1;
        handshake();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stale_busy", 32'(bus_if.busy), 32'd1);
            check("stale_in_ready", 32'(bus_if.in_ready), 32'd0);
            tick();
        end
        bus_if.mn_finish = 1'b0;
        tick();
        finish_pulse();

        // Reset mid-fill discards the partial vector.
        send_word(32'hAA, 1'b0);
        send_word(32'hBB, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus_if.in_ready), 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_x0",  bus_if.x_0, 32'h0);
        check("midrst_cnt", 32'(bus_if.vec_count), 32'd0);
        tick();
        send_vec(32'd1, 32'd2, 32'd3, 32'd4, 4, 1'b0);
        tick();
        handshake();
        finish_pulse();

        // Negative-looking words: cleared only when the clamp is built in.
        send_vec(32'h80000005, 32'h10, 32'hFFFFFFFF, 32'h3, 4, 1'b0);
        @(negedge clk);
        check("neg_x0", bus_if.x_0, mdl(32'h80000005));
        check("neg_x2", bus_if.x_2, mdl(32'hFFFFFFFF));
        tick();
        handshake();
        finish_pulse();

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
